frame_strobe_sequencer: RTL
===========================

# frame_strobe_sequencer

Column configuration write sequencer for the fabric's frame-based configuration path. It accepts one frame write at a time (column address, frame index, frame data) over a valid/ready handshake. It drives the shared FrameData bus, a one-hot column select and a one-hot FrameStrobe pulse, with programmable setup/strobe/hold spacing, into the per-column FrameStrobe daisy chain of the tile columns. Invalid addresses are dropped and flagged, and completed frames are counted.

## Interface
- MaxFramesPerCol, 20: FrameStrobe width; number of frames per column
- FrameBitsPerRow, 32: FrameData width
- NumColumns, 8: number of tile columns; ColBits = max(1, $clog2(NumColumns))
- FrameAddrBits, 5: WrFrame width; must satisfy 2**FrameAddrBits >= MaxFramesPerCol
- SetupCycles, 1: data-to-strobe setup, range 1..15
- StrobeCycles, 1: strobe pulse width, range 1..15
- HoldCycles, 1: strobe-to-data-release hold, range 0..15

Ports:
- CLK  in  1  config clock; all state on rising edge
- Reset  in  1  asynchronous, active-high reset
- WrValid  in  1  write request valid
- WrReady  out  1  sequencer can accept a request
- WrCol  in  ColBits  target column
- WrFrame  in  FrameAddrBits  target frame index
- WrData  in  FrameBitsPerRow  frame data
- FrameData  out  FrameBitsPerRow  registered frame data bus
- FrameStrobe  out  MaxFramesPerCol  one-hot frame strobe, registered
- ColSelect  out  NumColumns  one-hot column enable, registered
- Busy  out  1  high in every state except IDLE
- AddrErr  out  1  sticky invalid-address flag
- ErrClear  in  1  clears AddrErr
- FrameCount  out  16  completed-frame counter, wraps at 65535 to 0

## Operation
- States: IDLE, SETUP, STROBE, HOLD. A single phase counter (4 bits) times each state.
- IDLE: WrReady=1, ColSelect=0, FrameStrobe=0. FrameData holds the last written value.
- Accept = WrValid & WrReady on a clock edge.
- On a valid accept (WrCol < NumColumns and WrFrame < MaxFramesPerCol):
  - latch FrameData<=WrData
  - latch ColSelect<=1<<WrCol
  - latch the frame index
  - go to SETUP
- On an invalid accept, the handshake completes, but:
  - no outputs change except AddrErr<=1
  - the block stays in IDLE
  - FrameCount is unchanged
- SETUP: lasts SetupCycles cycles, strobe low, then go to STROBE.
- STROBE: FrameStrobe = 1<<frame index for StrobeCycles cycles.
  - On leaving STROBE: FrameCount += 1 and FrameStrobe <= 0.
  - If HoldCycles=0, go to IDLE, else go to HOLD.
- HOLD: lasts HoldCycles cycles, data and ColSelect held, strobe low, then go to IDLE.
- ColSelect clears on entry to IDLE. FrameData is not cleared.
- FrameStrobe is never multi-hot; at most one bit is high in any cycle.
- AddrErr:
  - set by an invalid accept, cleared by ErrClear
  - simultaneous set and clear: set wins
- WrReady=0 in SETUP/STROBE/HOLD. WrValid there is ignored and the requester holds it.

## Timing
- Reset values, applied asynchronously and immediately mid-operation:
  - state=IDLE, WrReady=1, Busy=0
  - FrameData=0, FrameStrobe=0, ColSelect=0
  - AddrErr=0, FrameCount=0
- Accept at edge k: FrameData/ColSelect valid and Busy=1 from cycle k+1.
- Strobe high during cycles k+1+SetupCycles .. k+SetupCycles+StrobeCycles.
- FrameCount updates at the edge ending the last strobe cycle.
- WrReady returns 1 in cycle k+1+SetupCycles+StrobeCycles+HoldCycles.
- Minimum request period = SetupCycles+StrobeCycles+HoldCycles+1 cycles; 4 with defaults.
- Back-to-back: a request held valid is accepted in the first IDLE cycle. There are no idle bubbles beyond that one cycle.
- An invalid request costs 1 cycle; the next request can be accepted at the following edge.
- Reset asserted during STROBE: the strobe drops asynchronously, the frame is not counted, and no partial pulse resumes after release.

## Test plan
- Default params, write (col 3, frame 7, data 0xDEADBEEF):
  - FrameData=0xDEADBEEF and ColSelect=0x08 from k+1
  - FrameStrobe=0x00080 only in cycle k+2
  - WrReady back at k+4, FrameCount=1
- Params Setup=2, Strobe=3, Hold=0, frame 19:
  - FrameStrobe bit 19 high for exactly cycles k+3..k+5
  - WrReady=1 at k+6
- Invalid frame 20, then invalid col 8 (NumColumns=8, ColBits=3 wraps col to 0):
  - frame 20: AddrErr=1, no strobe, FrameCount unchanged, WrReady stays 1
  - ErrClear in the same cycle as a new invalid accept: AddrErr stays 1
- WrValid held high for 3 consecutive frames 0,1,2:
  - strobes at cycles k+2, k+6, k+10
  - FrameCount=3
  - FrameStrobe never multi-hot
- Reset asserted mid-STROBE for 1 cycle:
  - all outputs at reset values at once
  - FrameCount=0, WrReady=1 after release
- FrameCount preloaded by 65535 writes, then one more write: FrameCount=0.

Source files
------------

// File: rtl/frame_strobe_sequencer.sv
// Frame write sequencer: drives FrameData, a one-hot ColSelect and a one-hot
// FrameStrobe pulse with programmable setup/strobe/hold spacing.
module frame_strobe_sequencer #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int NumColumns      = 8,
  parameter int FrameAddrBits   = 5,
  parameter int SetupCycles     = 1,
  parameter int StrobeCycles    = 1,
  parameter int HoldCycles      = 1,
  localparam int ColBits = (NumColumns > 1) ? $clog2(NumColumns) : 1
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic                       WrValid,
  output logic                       WrReady,
  input  logic [ColBits-1:0]         WrCol,
  input  logic [FrameAddrBits-1:0]   WrFrame,
  input  logic [FrameBitsPerRow-1:0] WrData,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic [NumColumns-1:0]      ColSelect,
  output logic                       Busy,
  output logic                       AddrErr,
  input  logic                       ErrClear,
  output logic [15:0]                FrameCount
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam logic [3:0] SetupLast  = 4'(SetupCycles - 1);
  localparam logic [3:0] StrobeLast = 4'(StrobeCycles - 1);
  localparam logic [3:0] HoldLast   = 4'(HoldCycles - 1);
  localparam int unsigned ColLimit   = NumColumns;
  localparam int unsigned FrameLimit = MaxFramesPerCol;
  localparam logic [NumColumns-1:0]      ColOne    = NumColumns'(1);
  localparam logic [MaxFramesPerCol-1:0] StrobeOne = MaxFramesPerCol'(1);

  state_t                   state, state_nxt;
  logic [3:0]               phase, phase_nxt;
  logic [FrameAddrBits-1:0] frame_idx;
  logic [15:0]              frame_count;
  logic                     accept, addr_ok;
  logic                     load, strobe_on, strobe_end, release_col;

  assign WrReady    = (state == IDLE);
  assign Busy       = (state != IDLE);
  assign FrameCount = frame_count;
  assign accept     = WrValid & WrReady;
  assign addr_ok    = (32'(WrCol) < ColLimit) && (32'(WrFrame) < FrameLimit);

  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase;
    load        = 1'b0;
    strobe_on   = 1'b0;
    strobe_end  = 1'b0;
    release_col = 1'b0;
    case (state)
      IDLE: begin
        if (accept && addr_ok) begin
          state_nxt = SETUP;
          phase_nxt = '0;
          load      = 1'b1;
        end
      end
      SETUP: begin
        if (phase == SetupLast) begin
          state_nxt = STROBE;
          phase_nxt = '0;
          strobe_on = 1'b1;
        end else begin
          phase_nxt = phase + 4'd1;
        end
      end
      STROBE: begin
        if (phase == StrobeLast) begin
          strobe_end = 1'b1;
          phase_nxt  = '0;
          if (HoldCycles == 0) begin
            state_nxt   = IDLE;
            release_col = 1'b1;
          end else begin
            state_nxt = HOLD;
          end
        end else begin
          phase_nxt = phase + 4'd1;
        end
      end
      HOLD: begin
        if (phase == HoldLast) begin
          state_nxt   = IDLE;
          phase_nxt   = '0;
          release_col = 1'b1;
        end else begin
          phase_nxt = phase + 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        phase_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      phase <= '0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
    end
  end

  // Strobe is registered one edge ahead so it is high exactly during STROBE.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      FrameData   <= '0;
      ColSelect   <= '0;
      FrameStrobe <= '0;
      frame_idx   <= '0;
      frame_count <= '0;
    end else begin
      if (load) begin
        FrameData <= WrData;
        ColSelect <= ColOne << WrCol;
        frame_idx <= WrFrame;
      end
      if (release_col) ColSelect <= '0;
      if (strobe_on) FrameStrobe <= StrobeOne << frame_idx;
      if (strobe_end) begin
        FrameStrobe <= '0;
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset)                    AddrErr <= 1'b0;
    else if (accept && !addr_ok)  AddrErr <= 1'b1;
    else if (ErrClear)            AddrErr <= 1'b0;
  end

endmodule
